// File: rtl/stdp_pkg.sv
// Shared types, widths and saturating arithmetic for the STDP learning controller.
package stdp_pkg;
  localparam int W_W   = 8;
  localparam int TR_W  = 4;
  localparam int N_SYN = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_SAMPLE, S_UPD0, S_UPD1, S_UPD2, S_UPD3, S_SUM
  } state_e;

  function automatic logic [W_W-1:0] sat_add(input logic [W_W-1:0] a,
                                             input logic [TR_W-1:0] b);
    logic [W_W:0] s;
    s = {1'b0, a} + {{(W_W+1-TR_W){1'b0}}, b};
    return s[W_W] ? {W_W{1'b1}} : s[W_W-1:0];
  endfunction

  function automatic logic [W_W-1:0] sat_sub(input logic [W_W-1:0] a,
                                             input logic [TR_W-1:0] b);
    logic [W_W-1:0] bx;
    bx = {{(W_W-TR_W){1'b0}}, b};
    return (a < bx) ? '0 : a - bx;
  endfunction
endpackage

// File: rtl/stdp_trace.sv
// One spike trace: loads TRACE_MAX on a spike, otherwise decays by one toward zero.
module stdp_trace
  import stdp_pkg::*;
#(
  parameter logic [TR_W-1:0] TRACE_MAX = 4'd15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            upd_i,
  input  logic            spike_i,
  output logic [TR_W-1:0] trace_o
);
  logic [TR_W-1:0] tr_q, tr_d;

  always_comb begin
    tr_d = tr_q;
    if (upd_i) begin
      if (spike_i)          tr_d = TRACE_MAX;
      else if (tr_q != '0)  tr_d = tr_q - TR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tr_q <= '0;
    else        tr_q <= tr_d;
  end

  assign trace_o = tr_q;
endmodule

// File: rtl/stdp_learn_ctrl.sv
// Timestep scheduler: samples spikes once per tick, applies STDP to four weights
// one per cycle, then publishes the weighted input current for the LIF neuron.
module stdp_learn_ctrl
  import stdp_pkg::*;
#(
  parameter logic [23:0]     TICK_DIV  = 24'd10_000_000,
  parameter logic [W_W-1:0]  W_INIT    = 8'd64,
  parameter logic [TR_W-1:0] TRACE_MAX = 4'd15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [N_SYN-1:0] pre_spike,
  input  logic             post_spike,
  input  logic             learn_en,
  input  logic [1:0]       wsel,
  output logic [W_W-1:0]   current,
  output logic [W_W-1:0]   weight_rd,
  output logic             busy
);
  state_e                       state_q;
  logic [23:0]                  cnt_q;
  logic [N_SYN-1:0]             pre_pend_q, pre_snap_q;
  logic                         post_pend_q, post_snap_q;
  logic [N_SYN-1:0][W_W-1:0]    w_q;
  logic [W_W-1:0]               current_q;
  logic [N_SYN-1:0][TR_W-1:0]   pre_tr;
  logic [TR_W-1:0]              post_tr;
  logic                         tick, trace_upd;
  logic [1:0]                   upd_sel;
  logic [W_W-1:0]               w_ltp, w_d;
  logic [W_W+1:0]               sum;
  logic [W_W-1:0]               sum_sat;

  assign tick      = ena && (cnt_q == TICK_DIV - 24'd1);
  assign trace_upd = (state_q == S_SUM);

  for (genvar g = 0; g < N_SYN; g++) begin : g_pre_tr
    stdp_trace #(.TRACE_MAX(TRACE_MAX)) u_pre_tr (
      .clk(clk), .rst_n(rst_n), .upd_i(trace_upd),
      .spike_i(pre_snap_q[g]), .trace_o(pre_tr[g])
    );
  end

  stdp_trace #(.TRACE_MAX(TRACE_MAX)) u_post_tr (
    .clk(clk), .rst_n(rst_n), .upd_i(trace_upd),
    .spike_i(post_snap_q), .trace_o(post_tr)
  );

  // LTP then LTD on the synapse owned by the current UPD state; traces are
  // still the previous step's values since they only move in SUM.
  always_comb begin
    case (state_q)
      S_UPD1:  upd_sel = 2'd1;
      S_UPD2:  upd_sel = 2'd2;
      S_UPD3:  upd_sel = 2'd3;
      default: upd_sel = 2'd0;
    endcase
    w_ltp = post_snap_q ? sat_add(w_q[upd_sel], pre_tr[upd_sel]) : w_q[upd_sel];
    w_d   = pre_snap_q[upd_sel] ? sat_sub(w_ltp, post_tr) : w_ltp;
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_SYN; i++)
      if (pre_snap_q[i]) sum = sum + {2'b00, w_q[i]};
    sum_sat = (|sum[W_W+1:W_W]) ? {W_W{1'b1}} : sum[W_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pre_pend_q  <= '0;
      post_pend_q <= 1'b0;
      pre_snap_q  <= '0;
      post_snap_q <= 1'b0;
      w_q         <= {N_SYN{W_INIT}};
      current_q   <= '0;
    end else begin
      if (ena) cnt_q <= tick ? '0 : cnt_q + 24'd1;
      // SAMPLE hands pending spikes to the snapshot, so this cycle's inputs start the next step
      pre_pend_q  <= ((state_q == S_SAMPLE) ? '0 : pre_pend_q) | (ena ? pre_spike : '0);
      post_pend_q <= ((state_q == S_SAMPLE) ? 1'b0 : post_pend_q) | (ena & post_spike);
      case (state_q)
        S_IDLE:   if (tick) state_q <= S_SAMPLE;
        S_SAMPLE: begin
          pre_snap_q  <= pre_pend_q;
          post_snap_q <= post_pend_q;
          state_q     <= S_UPD0;
        end
        S_UPD0, S_UPD1, S_UPD2, S_UPD3: begin
          if (learn_en) w_q[upd_sel] <= w_d;
          case (state_q)
            S_UPD0:  state_q <= S_UPD1;
            S_UPD1:  state_q <= S_UPD2;
            S_UPD2:  state_q <= S_UPD3;
            default: state_q <= S_SUM;
          endcase
        end
        S_SUM: begin
          current_q <= sum_sat;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign current   = current_q;
  assign weight_rd = w_q[wsel];
  assign busy      = (state_q != S_IDLE);
endmodule

// File: doc/stdp_learn_ctrl.md
# stdp_learn_ctrl

Timestep scheduler and STDP learning controller for the LIF neuron. It samples four presynaptic spike inputs and the neuron's output spike once per timestep, and sequences trace decay and saturating weight updates across four synapses in a fixed order. It then drives the weighted input current into the LIF neuron's `current` input. It sits between `ui_in` (presynaptic spikes) and the `lif` instance in the top level.

## Interface
- `TICK_DIV`, default 24'd10_000_000: clocks per timestep; minimum 8.
- `W_INIT`, default 8'd64: reset value of every weight.
- `TRACE_MAX`, default 4'd15: trace load value on a spike.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; **one clock; reset is asynchronous and active-low**.
- `ena`  in  1  design enable.
- `pre_spike`  in  4  presynaptic spike pulses, any width ≥1 clk.
- `post_spike`  in  1  LIF output spike.
- `learn_en`  in  1  1 = apply STDP weight changes.
- `wsel`  in  2  weight read-back select.
- `current`  out  8  input current to LIF.
- `weight_rd`  out  8  weight[`wsel`], combinational.
- `busy`  out  1  high whenever FSM is not IDLE.

## Operation
- Sticky capture regs `pre_pend[3:0]`, `post_pend`: OR in inputs every cycle while `ena`=1.
- Tick counter counts 0..TICK_DIV-1 while `ena`=1 and asserts `tick` on wrap; it holds when `ena`=0.
- FSM: IDLE → SAMPLE → UPD0 → UPD1 → UPD2 → UPD3 → SUM → IDLE.
  - IDLE→SAMPLE on `tick`; other transitions are unconditional, one cycle each.
- SAMPLE: `pre_snap`←`pre_pend`, `post_snap`←`post_pend`. Pending regs are loaded with the inputs present this cycle, so a spike arriving during SAMPLE belongs to the next step.
- UPDi (`learn_en`=1), using trace values from before this step:
  - LTP: if `post_snap`, `w[i] += pre_trace[i]`, saturating at 255.
  - LTD: then, if `pre_snap[i]`, `w[i] -= post_trace`, saturating at 0.
  - Simultaneous pre and post spikes apply both, LTP first.
  - With `learn_en`=0, weights are unchanged.
- SUM:
  - `current` ← Σ w[i] over i with `pre_snap[i]`=1, using the updated weights, 10-bit intermediate, saturated to 255.
  - Traces: spike in snapshot → `TRACE_MAX`; otherwise decrement, floor 0.
- `ena`=0 mid-step: the step in progress completes; no new tick occurs.
- Reset (asynchronous, mid-step allowed): FSM→IDLE, counter 0, pending and snap regs 0, traces 0, weights `W_INIT`, `current` 0, `busy` 0.

## Timing
- Tick at cycle T → SAMPLE T+1, UPD0–3 T+2..T+5, SUM T+6.
- `current` and the new weights are visible at T+7 and held until the next SUM.
- `busy` is high T+1..T+6.
- `weight_rd` reflects register contents with zero latency.
- Tick-to-tick spacing of `TICK_DIV` ≥ 8 guarantees the FSM is always IDLE at a tick.

## Structure
- Package `stdp_pkg`:
  - FSM state enum.
  - `W_W`=8, `TR_W`=4, `N_SYN`=4.
  - Saturating add/sub functions.
- One sub-module, `stdp_trace`: a single trace register with load-on-spike and saturating decay. It is instanced five times (4 pre, 1 post).
- The weight array, FSM and summation stay in `stdp_learn_ctrl`.

## Test plan
All scenarios use `TICK_DIV`=8.
- **Reset:** release reset → `weight_rd`=64 for all `wsel`, `current`=0, `busy`=0. Then assert `rst_n` low during UPD2 → same values immediately.
- **No learning, current sum:** `learn_en`=0, pre=4'b0101 pulsed one cycle before the tick → at T+7 `current`=128; weights stay 64.
- **LTP:** pre[0] spikes in step k, post spikes in step k+1, `learn_en`=1 → after step k+1, w[0]=64+15=79 and the other weights stay 64.
- **LTD:** post spikes in step k, pre[1] spikes in step k+1 → w[1]=64−15=49.
- **Saturation:**
  - Repeated pre0→post pairs → w[0] clamps at 255, never wraps.
  - Repeated post→pre1 pairs → w[1] clamps at 0.
  - All four weights at 255 with pre=4'b1111 → `current`=255.
- **Boundary capture:** pre[2] pulse exactly in the SAMPLE cycle → excluded from this step's `current`, included in the next. `ena` low for 20 cycles → no `busy`, counter resumes without skipping.
